// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame path: default widths and the
// frame assembler state encoding.
package uart_alu_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;
   localparam int NB_STATE    = 3;

   typedef enum logic [NB_STATE-1:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

endpackage

// File: rtl/uart_alu_interface_frame_timer.sv
// Saturating inter-byte timer. Counts enabled cycles since the last clear and
// flags when TIMEOUT_CYC cycles have elapsed. TIMEOUT_CYC = 0 never expires.
module frame_timer #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYC);

   logic [TW-1:0] cnt_q;

   // Clear has priority; the count holds once it reaches the limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && (cnt_q != LIMIT)) begin
         cnt_q <= cnt_q + TW'(1);
      end
   end

   assign expired = (TIMEOUT_CYC != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_alu_interface.sv
// Frame assembler: collects operand A, operand B and opcode from the UART
// receiver, holds them for the ALU, then sends the ALU result as one byte.
// Handshake: rx_done_tick / tx_done_tick are single-cycle strobes that are
// always accepted (no backpressure); a byte arriving while a result is
// pending is dropped and reported on overrun.
module uart_alu_interface
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA     = NB_DATA_DEF,
   parameter int NB_OP       = NB_OP_DEF,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_done_tick,
   input  logic [NB_DATA-1:0] rx_data,
   input  logic [NB_DATA-1:0] alu_result,
   input  logic               tx_done_tick,
   output logic [NB_DATA-1:0] data_a,
   output logic [NB_DATA-1:0] data_b,
   output logic [NB_OP-1:0]   op,
   output logic               tx_start,
   output logic [NB_DATA-1:0] tx_data,
   output logic               overrun,
   output logic               frame_timeout,
   output logic [NB_STATE-1:0] dbg_state
);

   state_t             state_q, state_d;
   logic [NB_DATA-1:0] data_a_q, data_a_d;
   logic [NB_DATA-1:0] data_b_q, data_b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q;
   logic               accept;
   logic               tmr_en;
   logic               tmr_clr;
   logic               tmr_expired;

   // The timer only runs while a frame is partially collected.
   assign tmr_en  = (state_q == WAIT_B) || (state_q == WAIT_OP);
   assign tmr_clr = accept || frame_timeout || !tmr_en;

   frame_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_frame_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clr),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   // Next-state, register-update and strobe decode; a received byte beats
   // a same-cycle timer expiry.
   always_comb begin
      state_d       = state_q;
      data_a_d      = data_a_q;
      data_b_d      = data_b_q;
      op_d          = op_q;
      tx_data_d     = tx_data_q;
      accept        = 1'b0;
      overrun       = 1'b0;
      frame_timeout = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (rx_done_tick) begin
               data_a_d = rx_data;
               accept   = 1'b1;
               state_d  = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done_tick) begin
               data_b_d = rx_data;
               accept   = 1'b1;
               state_d  = WAIT_OP;
            end else if (tmr_expired) begin
               frame_timeout = 1'b1;
               state_d       = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               op_d    = rx_data[NB_OP-1:0];
               accept  = 1'b1;
               state_d = SEND;
            end else if (tmr_expired) begin
               frame_timeout = 1'b1;
               state_d       = WAIT_A;
            end
         end
         SEND: begin
            tx_data_d = alu_result;
            overrun   = rx_done_tick;
            state_d   = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done_tick) begin
               state_d = WAIT_A;
               if (rx_done_tick) begin
                  data_a_d = rx_data;
                  accept   = 1'b1;
                  state_d  = WAIT_B;
               end
            end else begin
               overrun = rx_done_tick;
            end
         end
         default: state_d = WAIT_A;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= WAIT_A;
         data_a_q   <= '0;
         data_b_q   <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= (state_d == SEND);
      end
   end

   assign data_a    = data_a_q;
   assign data_b    = data_b_q;
   assign op        = op_q;
   assign tx_start  = tx_start_q;
   assign dbg_state = state_q;
   // During SEND the ALU inputs are already stable, so the result is passed
   // straight through; afterwards the captured copy holds until tx_done_tick.
   assign tx_data   = (state_q == SEND) ? alu_result : tx_data_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface with a short frame timeout and an adder ALU.
module tb_uart_alu_interface;
   import uart_alu_pkg::*;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
   localparam int TO      = 50;

   logic               clk;
   logic               reset;
   logic               rx_done_tick;
   logic [NB_DATA-1:0] rx_data;
   logic [NB_DATA-1:0] alu_result;
   logic               tx_done_tick;
   logic [NB_DATA-1:0] data_a;
   logic [NB_DATA-1:0] data_b;
   logic [NB_OP-1:0]   op;
   logic               tx_start;
   logic [NB_DATA-1:0] tx_data;
   logic               overrun;
   logic               frame_timeout;
   logic [2:0]         dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [NB_DATA-1:0] exp_q[$];

   uart_alu_interface #(
      .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .alu_result(alu_result), .tx_done_tick(tx_done_tick), .data_a(data_a),
      .data_b(data_b), .op(op), .tx_start(tx_start), .tx_data(tx_data),
      .overrun(overrun), .frame_timeout(frame_timeout), .dbg_state(dbg_state)
   );

   // ALU stand-in: adder on the registered operands
   assign alu_result = data_a + data_b;

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_done_tick = 1'b1;
      rx_data      = b;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
      logic [7:0] sum;
      logic [5:0] o_low;
      sum   = a + b;
      o_low = o[5:0];
      send_byte(a);
      idle(1);
      send_byte(b);
      idle(2);
      exp_q.push_back(sum);
      send_byte(o);
      check("frm_data_a", data_a, a);
      check("frm_data_b", data_b, b);
      check("frm_op", op, o_low);
      check("frm_tx_start", tx_start, 1);
   endtask

   task automatic finish_tx();
      @(negedge clk);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      check("tx_done_state", dbg_state, WAIT_A);
   endtask

   // scoreboard: compare each launched byte with the expected queue
   always @(negedge clk) begin
      if (tx_start) begin
         if (exp_q.size() == 0) check("tx_unexpected", 1, 0);
         else check("tx_data", tx_data, exp_q.pop_front());
      end
   end

   initial begin
      logic [7:0] ra, rb, ro;
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rx_data      = '0;
      tx_done_tick = 1'b0;

      // reset state
      #1 reset = 1'b0;
      #2;
      check("rst_data_a", data_a, 0);
      check("rst_data_b", data_b, 0);
      check("rst_op", op, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", frame_timeout, 0);
      check("rst_state", dbg_state, WAIT_A);
      @(negedge clk);
      reset = 1'b1;
      idle(2);

      // normal frame
      send_frame(8'h05, 8'h03, 8'h20);
      idle(1);
      check("tx_start_pulse", tx_start, 0);
      check("st_wait_tx", dbg_state, WAIT_TX);
      idle(5);
      check("hold_wait_tx", dbg_state, WAIT_TX);
      check("tx_data_hold", tx_data, 8'h08);
      finish_tx();

      // opcode masking
      send_frame(8'h10, 8'h20, 8'hE5);
      check("op_mask", op, 6'h25);
      idle(1);
      finish_tx();

      // overrun in SEND and in WAIT_TX
      send_frame(8'h01, 8'h02, 8'h03);
      rx_done_tick = 1'b1;
      rx_data      = 8'hAA;
      #1 check("ovr_send", overrun, 1);
      @(negedge clk);
      rx_done_tick = 1'b0;
      check("ovr_st", dbg_state, WAIT_TX);
      rx_done_tick = 1'b1;
      rx_data      = 8'hAA;
      #1 check("ovr_wait_tx", overrun, 1);
      @(negedge clk);
      rx_done_tick = 1'b0;
      #1;
      check("ovr_clear", overrun, 0);
      check("ovr_data_a", data_a, 8'h01);
      check("ovr_data_b", data_b, 8'h02);
      check("ovr_op", op, 6'h03);
      check("ovr_still_wait", dbg_state, WAIT_TX);

      // back-to-back: new A with tx_done_tick
      @(negedge clk);
      rx_done_tick = 1'b1;
      tx_done_tick = 1'b1;
      rx_data      = 8'h11;
      #1 check("b2b_no_ovr", overrun, 0);
      @(negedge clk);
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b0;
      check("b2b_data_a", data_a, 8'h11);
      check("b2b_state", dbg_state, WAIT_B);
      check("b2b_tx_hold", tx_data, 8'h03);
      send_byte(8'h22);
      exp_q.push_back(8'h33);
      send_byte(8'h01);
      check("b2b_tx_start", tx_start, 1);
      idle(1);
      finish_tx();

      // timeout after A
      send_byte(8'h40);
      repeat (TO - 1) @(negedge clk);
      check("to_early", frame_timeout, 0);
      @(negedge clk);
      check("to_pulse", frame_timeout, 1);
      @(negedge clk);
      check("to_state", dbg_state, WAIT_A);
      check("to_pulse_end", frame_timeout, 0);
      check("to_keep_a", data_a, 8'h40);
      check("to_keep_b", data_b, 8'h22);
      send_byte(8'h07);
      check("to_new_a", data_a, 8'h07);
      check("to_new_state", dbg_state, WAIT_B);

      // byte on the expiry cycle wins
      repeat (TO - 1) @(negedge clk);
      @(negedge clk);
      rx_done_tick = 1'b1;
      rx_data      = 8'h09;
      #1 check("to_race", frame_timeout, 0);
      @(negedge clk);
      rx_done_tick = 1'b0;
      check("race_data_b", data_b, 8'h09);
      check("race_state", dbg_state, WAIT_OP);
      exp_q.push_back(8'h10);
      send_byte(8'hC0);
      check("race_op", op, 6'h00);
      check("race_tx_start", tx_start, 1);
      idle(1);
      finish_tx();

      // asynchronous reset mid-frame
      send_byte(8'h55);
      send_byte(8'h66);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mrst_data_a", data_a, 0);
      check("mrst_data_b", data_b, 0);
      check("mrst_op", op, 0);
      check("mrst_tx_data", tx_data, 0);
      check("mrst_state", dbg_state, WAIT_A);
      @(negedge clk);
      reset = 1'b1;
      idle(1);
      send_frame(8'h0A, 8'h0B, 8'h0C);
      idle(1);
      finish_tx();

      // random frames
      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         ro = 8'($urandom_range(0, 255));
         send_frame(ra, rb, ro);
         idle(1 + $urandom_range(0, 3));
         finish_tx();
      end

      // final report
      idle(3);
      check("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Frame assembler between the UART receiver and the ALU/transmitter. It collects three consecutive received bytes (operand A, operand B, opcode) into registers that drive the ALU. It then captures the ALU result and launches one byte on the UART transmitter. Upstream is the receiver (`rx_done_tick`/`dout`); downstream are the combinational ALU and the UART transmitter (`tx_start`/`tx_done_tick`).

## Interface
Parameters:
- `NB_DATA`, 8 — UART byte width and ALU operand/result width.
- `NB_OP`, 6 — opcode width; the opcode is taken from the low `NB_OP` bits of the third byte.
- `TIMEOUT_CYC`, 100000 — clock cycles allowed between bytes of one frame. 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_done_tick`  in  1  one-cycle pulse: `rx_data` is valid.
- `rx_data`  in  NB_DATA  received byte.
- `alu_result`  in  NB_DATA  combinational ALU output.
- `tx_done_tick`  in  1  one-cycle pulse: transmitter finished its byte.
- `data_a`  out  NB_DATA  registered operand A to the ALU.
- `data_b`  out  NB_DATA  registered operand B to the ALU.
- `op`  out  NB_OP  registered opcode to the ALU.
- `tx_start`  out  1  one-cycle pulse that starts transmission.
- `tx_data`  out  NB_DATA  byte to transmit; held stable from `tx_start` until `tx_done_tick`.
- `overrun`  out  1  one-cycle pulse when a received byte is dropped.
- `frame_timeout`  out  1  one-cycle pulse when a partial frame is abandoned.

## Operation
States, with reset state `WAIT_A`:
- `WAIT_A`: on `rx_done_tick`, `data_a <= rx_data`; go to `WAIT_B`.
- `WAIT_B`: on `rx_done_tick`, `data_b <= rx_data`; go to `WAIT_OP`.
- `WAIT_OP`: on `rx_done_tick`, `op <= rx_data[NB_OP-1:0]`; go to `SEND`.
- `SEND`: `tx_data <= alu_result` and `tx_start = 1` for this cycle only; go to `WAIT_TX`.
- `WAIT_TX`: on `tx_done_tick`, go to `WAIT_A`.

Byte handling outside the collecting states:
- `rx_done_tick` in `SEND` or in `WAIT_TX` (without a same-cycle `tx_done_tick`): byte dropped, `overrun` pulses for that cycle, registers unchanged.
- `rx_done_tick` together with `tx_done_tick` in `WAIT_TX`: byte captured as A, next state `WAIT_B`, no overrun.

Frame timeout:
- Inter-byte timer clears on every accepted byte and on entry to `WAIT_A`.
- Timer counts only in `WAIT_B` and `WAIT_OP`.
- At `TIMEOUT_CYC` cycles without a byte: go to `WAIT_A` and pulse `frame_timeout`. `data_a`, `data_b` and `op` keep their old values.
- Timer expiry in the same cycle as `rx_done_tick`: the byte wins; it is captured and the timer clears.
- `tx_done_tick` outside `WAIT_TX` is ignored.

Reset (asserted, from any state, including mid-frame or mid-transmission):
- State returns to `WAIT_A`; timer clears.
- `data_a`, `data_b`, `op`, `tx_data` = 0.
- `tx_start`, `overrun`, `frame_timeout` = 0.

Arithmetic and widths:
- Timer width is `$clog2(TIMEOUT_CYC+1)`.
- Timer saturates; it never wraps.
- Upper `NB_DATA-NB_OP` bits of the opcode byte are discarded.

## Timing
- Operand and opcode registers update on the edge at which `rx_done_tick` is sampled high.
- `tx_start` is asserted exactly one cycle after the opcode is captured. The ALU therefore has one full cycle with stable inputs.
- `tx_data` is registered in the `SEND` cycle and is valid while `tx_start` is high.
- Latency from the opcode `rx_done_tick` to `tx_start` is 1 cycle.
- `overrun` and `frame_timeout` are combinational decodes of registered state plus the input ticks, valid in the same cycle as the triggering tick or expiry.
- `tx_start` is a registered state decode: high only in `SEND`.
- A new frame may begin in the same cycle as `tx_done_tick`.

## Structure
- Shared package `uart_alu_pkg`:
  - state encoding localparams (`WAIT_A`…`WAIT_TX`, 3 bits);
  - `NB_DATA` and `NB_OP` defaults.
  The ALU and the top level reuse these.
- One sub-module: `frame_timer`, a saturating counter with `clear`, `enable` and `expired` ports, parameterised by `TIMEOUT_CYC`.
- Everything else is a single two-process FSM: a registered state process and a combinational next-state process.

## Test plan
- Normal frame: bytes 0x05, 0x03, 0x20 with `alu_result` modelled as A+B. Expect `data_a`=0x05, `data_b`=0x03, `op`=0x20. `tx_start` pulses 1 cycle after the third tick with `tx_data`=0x08. `tx_done_tick` returns the FSM to `WAIT_A`.
- Opcode masking: third byte 0xE5 → `op`=0x25.
- Overrun: `rx_done_tick` with 0xAA during `WAIT_TX` → `overrun` pulses once; registers unchanged; the FSM still needs `tx_done_tick`.
- Back-to-back: `rx_done_tick`(0x11) in the same cycle as `tx_done_tick` → `data_a`=0x11, state `WAIT_B`, no overrun.
- Timeout with `TIMEOUT_CYC`=50:
  - A, then no byte for 50 cycles → `frame_timeout` pulses and the next byte is taken as A.
  - Byte arriving exactly on the expiry cycle → captured as B, no timeout.
- Reset mid-frame: reset asserted after A and B, asynchronously between edges → all outputs 0 immediately; a subsequent 3-byte frame completes normally.
